// File: rtl/serial_adder_nbit.sv
//==============================================================================
// Module      : serial_adder_nbit
// Description : Multi-cycle adder/subtractor, CHUNK bits per clock, with a
//               start/busy/done handshake and latched operands.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_adder_nbit #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] acc_shift;

    // Operands shift right each RUN cycle, so the active chunk is always at the bottom.
    assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, c_q};

    generate
        if (CHUNK == WIDTH) begin : g_single_chunk
            assign acc_shift = chunk_sum[CHUNK-1:0];
        end else begin : g_multi_chunk
            assign acc_shift = {chunk_sum[CHUNK-1:0], acc_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            k_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        k_d     = k_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    c_d     = Sub ^ Cin;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> CHUNK;
                b_d   = b_q >> CHUNK;
                c_d   = chunk_sum[CHUNK];
                acc_d = acc_shift;
                k_d   = k_q + KW'(1);
                if (k_q == KW'(N - 1)) begin
                    // On the last chunk, bit CHUNK-1 of each operand is the word MSB.
                    s_d     = acc_shift;
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = (a_q[CHUNK-1] == b_q[CHUNK-1]) &&
                              (chunk_sum[CHUNK-1] != a_q[CHUNK-1]);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_nbit.sv
//==============================================================================
// Module      : tb_serial_adder_nbit
// Description : Self-checking bench for serial_adder_nbit across four
//               WIDTH/CHUNK configurations.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_adder_nbit;

    logic        clk;
    logic        rst_n;
    logic [3:0]  start_v;
    logic [15:0] a_bus, b_bus;
    logic        cin, sub;
    logic [3:0]  busy_v, done_v, cout_v, ovf_v;
    logic [7:0]  s0;
    logic [3:0]  s1;
    logic [15:0] s2;
    logic [7:0]  s3;
    logic [15:0] s_w [4];

    int checks;
    int failures;

    // idx0: (8,2)  idx1: (4,4)  idx2: (16,4)  idx3: (8,1)
    serial_adder_nbit #(.WIDTH(8), .CHUNK(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .A(a_bus[7:0]), .B(b_bus[7:0]),
        .Cin(cin), .Sub(sub), .busy(busy_v[0]), .done(done_v[0]), .S(s0),
        .Cout(cout_v[0]), .Ovf(ovf_v[0]));
    serial_adder_nbit #(.WIDTH(4), .CHUNK(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .A(a_bus[3:0]), .B(b_bus[3:0]),
        .Cin(cin), .Sub(sub), .busy(busy_v[1]), .done(done_v[1]), .S(s1),
        .Cout(cout_v[1]), .Ovf(ovf_v[1]));
    serial_adder_nbit #(.WIDTH(16), .CHUNK(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .A(a_bus), .B(b_bus),
        .Cin(cin), .Sub(sub), .busy(busy_v[2]), .done(done_v[2]), .S(s2),
        .Cout(cout_v[2]), .Ovf(ovf_v[2]));
    serial_adder_nbit #(.WIDTH(8), .CHUNK(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .A(a_bus[7:0]), .B(b_bus[7:0]),
        .Cin(cin), .Sub(sub), .busy(busy_v[3]), .done(done_v[3]), .S(s3),
        .Cout(cout_v[3]), .Ovf(ovf_v[3]));

    assign s_w[0] = {8'h00, s0};
    assign s_w[1] = {12'h000, s1};
    assign s_w[2] = s2;
    assign s_w[3] = {8'h00, s3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic su);
        logic [16:0] mask, sum;
        logic [15:0] am, beff, s;
        logic        co, ov;
        mask = (17'd1 << w) - 17'd1;
        am   = a & mask[15:0];
        beff = (su ? ~b : b) & mask[15:0];
        sum  = {1'b0, am} + {1'b0, beff} + {16'd0, su ^ ci};
        s    = sum[15:0] & mask[15:0];
        co   = sum[w];
        ov   = (am[w-1] == beff[w-1]) && (s[w-1] != am[w-1]);
        return {ov, co, s};
    endfunction

    // Called just after a rising edge; returns once the done pulse has been observed and has dropped.
    task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic su,
                          output logic [15:0] s, output logic co, output logic ov, output int lat);
        a_bus = a; b_bus = b; cin = ci; sub = su;
        start_v[idx] = 1'b1;
        @(posedge clk); #1;
        start_v[idx] = 1'b0;
        chk("busy_after_start", {31'd0, busy_v[idx]}, 32'd1);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done_v[idx]) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
        s  = s_w[idx];
        co = cout_v[idx];
        ov = ovf_v[idx];
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done_v[idx]}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic       cin, sub;
        logic [7:0] s;
        logic       cout, ovf;
    } vec_t;

    initial begin
        vec_t        tbl [6];
        logic [15:0] rs;
        logic        rc, ro;
        logic [17:0] m;
        int          lat, d1, d2, npulse, w;

        checks = 0; failures = 0;
        start_v = 4'h0;
        tbl[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[5] = '{8'h10, 8'h05, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b0};

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_bus = 16'($urandom); b_bus = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom); start_v = 4'($urandom);
            @(posedge clk); #1;
        end
        chk("rst_busy", {28'd0, busy_v}, 32'd0);
        chk("rst_done", {28'd0, done_v}, 32'd0);
        chk("rst_S0", {16'd0, s_w[0]}, 32'd0);
        chk("rst_S2", {16'd0, s_w[2]}, 32'd0);
        chk("rst_cout_ovf", {24'd0, cout_v, ovf_v}, 32'd0);
        start_v = 4'h0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_op(0, {8'h00, tbl[i].a}, {8'h00, tbl[i].b}, tbl[i].cin, tbl[i].sub, rs, rc, ro, lat);
            chk($sformatf("vec%0d_S", i), {16'd0, rs}, {24'd0, tbl[i].s});
            chk($sformatf("vec%0d_Cout", i), {31'd0, rc}, {31'd0, tbl[i].cout});
            chk($sformatf("vec%0d_Ovf", i), {31'd0, ro}, {31'd0, tbl[i].ovf});
            chk($sformatf("vec%0d_latency", i), lat, 32'd4);
        end

        // Reset in the second RUN cycle aborts the operation.
        a_bus = 16'h00F0; b_bus = 16'h0001; cin = 1'b0; sub = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy_v[0]}, 32'd0);
        chk("midrst_S", {16'd0, s_w[0]}, 32'd0);
        chk("midrst_cout_ovf", {30'd0, cout_v[0], ovf_v[0]}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        npulse = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done_v[0]) npulse++;
        end
        chk("midrst_no_done", npulse, 32'd0);
        run_op(0, 16'h0010, 16'h0020, 1'b0, 1'b0, rs, rc, ro, lat);
        chk("postrst_S", {16'd0, rs}, 32'h30);
        chk("postrst_latency", lat, 32'd4);

        // Operand changes and a stray start during RUN must not disturb the result.
        a_bus = 16'h0012; b_bus = 16'h0034; cin = 1'b0; sub = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        a_bus = 16'h00FF; b_bus = 16'h00FF; cin = 1'b1; sub = 1'b1;
        npulse = 0; d1 = -1; rs = '0; rc = 1'b1; ro = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            start_v[0] = (c == 1);
            if (done_v[0]) begin
                npulse++;
                if (d1 < 0) begin
                    d1 = c; rs = s_w[0]; rc = cout_v[0]; ro = ovf_v[0];
                end
            end
        end
        start_v[0] = 1'b0;
        chk("hs_pulses", npulse, 32'd1);
        chk("hs_latency", d1, 32'd4);
        chk("hs_S", {16'd0, rs}, 32'h46);
        chk("hs_cout_ovf", {30'd0, rc, ro}, 32'd0);

        // start held high: back-to-back operations every N+2 cycles.
        a_bus = 16'h0001; b_bus = 16'h0002; cin = 1'b0; sub = 1'b0;
        start_v[0] = 1'b1;
        d1 = -1; d2 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done_v[0]) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
        end
        start_v[0] = 1'b0;
        chk("held_first_done", d1, 32'd5);
        chk("held_spacing", d2 - d1, 32'd6);
        chk("held_S", {16'd0, s_w[0]}, 32'h03);
        for (int c = 0; c < 20; c++) begin
            if (!busy_v[0] && !done_v[0]) break;
            @(posedge clk); #1;
        end
        chk("held_drain", {30'd0, busy_v[0], done_v[0]}, 32'd0);

        // CHUNK == WIDTH: single RUN cycle.
        run_op(1, 16'h0009, 16'h0008, 1'b0, 1'b0, rs, rc, ro, lat);
        chk("n1_S", {16'd0, rs}, 32'h1);
        chk("n1_cout_ovf", {30'd0, rc, ro}, 32'd3);
        chk("n1_latency", lat, 32'd1);

        for (int idx = 2; idx <= 3; idx++) begin
            w = (idx == 2) ? 16 : 8;
            for (int i = 0; i < 6; i++) begin
                logic [15:0] ra, rb;
                logic        rci, rsu;
                ra = 16'($urandom); rb = 16'($urandom);
                if (i == 0) begin ra = 16'hFFFF; rb = 16'h0000; end
                rci = 1'($urandom); rsu = 1'($urandom);
                m = model(w, ra, rb, rci, rsu);
                run_op(idx, ra, rb, rci, rsu, rs, rc, ro, lat);
                chk($sformatf("sweep%0d_%0d_result", idx, i), {14'd0, ro, rc, rs}, {14'd0, m});
                chk($sformatf("sweep%0d_%0d_latency", idx, i), lat, (idx == 2) ? 32'd4 : 32'd8);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
